// File: rtl/cluster_seq_pkg.sv
// Shared types and default geometry for the cluster job sequencer.
package cluster_seq_pkg;

  localparam int DEF_WR_CYC_NUM  = 4;
  localparam int DEF_FILTER_NUM  = 4;
  localparam int DEF_IFM_NUM     = 8;
  localparam int DEF_OUT_BUF_NUM = 4;
  localparam int DEF_CU_NUM      = 8;

  localparam int DEF_WC_W = $clog2(DEF_WR_CYC_NUM);
  localparam int DEF_FL_W = $clog2(DEF_FILTER_NUM);
  localparam int DEF_IL_W = $clog2(DEF_IFM_NUM);
  localparam int DEF_OB_W = $clog2(DEF_OUT_BUF_NUM);
  localparam int DEF_CU_W = $clog2(DEF_CU_NUM);

  typedef enum logic [2:0] {
    IDLE, LD_FLT, LD_IFM, RUN_START, RUN_WAIT, DRAIN, DONE
  } seq_state_e;

endpackage

// File: rtl/seq_nested_cnt.sv
// Two-level counter: inner walks 0..in_last, outer steps on each inner wrap.
// Both levels return to zero after the final count so the next phase starts clean.
module seq_nested_cnt
  import cluster_seq_pkg::*;
#(
  parameter int IN_W  = DEF_CU_W,
  parameter int OUT_W = DEF_OB_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  in_last,
  input  logic [OUT_W-1:0] out_last,
  output logic [IN_W-1:0]  in_cnt,
  output logic [OUT_W-1:0] out_cnt,
  output logic             last
);

  logic in_wrap;

  assign in_wrap = (in_cnt == in_last);
  assign last    = in_wrap && (out_cnt == out_last);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (clr || (en && last)) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (en) begin
      if (in_wrap) begin
        in_cnt  <= '0;
        out_cnt <= out_cnt + 1'b1;
      end else begin
        in_cnt  <= in_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cluster_seq_ctrl.sv
// Job sequencer: filter load, then per IFM chunk load / run / drain, with
// ping-pong selects for both memories and a valid/ready output drain.
module cluster_seq_ctrl
  import cluster_seq_pkg::*;
#(
  parameter int WR_CYC_NUM  = DEF_WR_CYC_NUM,
  parameter int FILTER_NUM  = DEF_FILTER_NUM,
  parameter int IFM_NUM     = DEF_IFM_NUM,
  parameter int OUT_BUF_NUM = DEF_OUT_BUF_NUM,
  parameter int CU_NUM      = DEF_CU_NUM
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [$clog2(FILTER_NUM)-1:0]  filter_last_i,
  input  logic [$clog2(IFM_NUM)-1:0]     ifm_last_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           filter_wr_valid_o,
  output logic [$clog2(WR_CYC_NUM)-1:0]  filter_wr_count_o,
  output logic [$clog2(OUT_BUF_NUM)-1:0] filter_wr_order_sel_o,
  output logic                           filter_wr_sel_o,
  output logic                           filter_rd_sel_o,
  output logic                           ifm_wr_valid_o,
  output logic [$clog2(WR_CYC_NUM)-1:0]  ifm_wr_count_o,
  output logic [$clog2(IFM_NUM)-1:0]     ifm_wr_chunk_count_o,
  output logic                           ifm_wr_sel_o,
  output logic                           ifm_rd_sel_o,
  output logic                           run_valid_o,
  output logic                           total_chunk_start_o,
  input  logic                           total_chunk_end_i,
  output logic [$clog2(OUT_BUF_NUM)-1:0] acc_buf_sel_o,
  output logic [$clog2(OUT_BUF_NUM)-1:0] out_buf_sel_o,
  output logic [$clog2(CU_NUM)-1:0]      com_unit_out_buf_sel_o,
  output logic                           out_vld_o,
  input  logic                           out_rdy_i
);

  localparam int WC_W = $clog2(WR_CYC_NUM);
  localparam int FL_W = $clog2(FILTER_NUM);
  localparam int IL_W = $clog2(IFM_NUM);
  localparam int OB_W = $clog2(OUT_BUF_NUM);
  localparam int CU_W = $clog2(CU_NUM);

  seq_state_e      state;
  logic [FL_W-1:0] flt_last;
  logic [IL_W-1:0] ifm_last;
  logic [IL_W-1:0] chunk;
  logic            flt_done, ifm_done, drn_done, drn_en, cnt_clr;
  logic            ifm_cnt_unused;

  assign cnt_clr              = (state == IDLE);
  assign drn_en               = (state == DRAIN) && out_vld_o && out_rdy_i;
  assign ifm_wr_chunk_count_o = chunk;

  seq_nested_cnt #(.IN_W(WC_W), .OUT_W(OB_W)) u_flt_cnt (
    .clk_i, .rst_i, .clr(cnt_clr), .en(state == LD_FLT),
    .in_last(WC_W'(WR_CYC_NUM - 1)), .out_last(OB_W'(flt_last)),
    .in_cnt(filter_wr_count_o), .out_cnt(filter_wr_order_sel_o), .last(flt_done)
  );

  // IFM load is a single chunk of beats: outer level pinned to one step.
  seq_nested_cnt #(.IN_W(WC_W), .OUT_W(1)) u_ifm_cnt (
    .clk_i, .rst_i, .clr(cnt_clr), .en(state == LD_IFM),
    .in_last(WC_W'(WR_CYC_NUM - 1)), .out_last(1'b0),
    .in_cnt(ifm_wr_count_o), .out_cnt(ifm_cnt_unused), .last(ifm_done)
  );

  seq_nested_cnt #(.IN_W(CU_W), .OUT_W(OB_W)) u_drn_cnt (
    .clk_i, .rst_i, .clr(cnt_clr), .en(drn_en),
    .in_last(CU_W'(CU_NUM - 1)), .out_last(OB_W'(flt_last)),
    .in_cnt(com_unit_out_buf_sel_o), .out_cnt(out_buf_sel_o), .last(drn_done)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state               <= IDLE;
      flt_last            <= '0;
      ifm_last            <= '0;
      chunk               <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      filter_wr_valid_o   <= 1'b0;
      filter_wr_sel_o     <= 1'b0;
      filter_rd_sel_o     <= 1'b0;
      ifm_wr_valid_o      <= 1'b0;
      ifm_wr_sel_o        <= 1'b0;
      ifm_rd_sel_o        <= 1'b0;
      run_valid_o         <= 1'b0;
      total_chunk_start_o <= 1'b0;
      acc_buf_sel_o       <= '0;
      out_vld_o           <= 1'b0;
    end else begin
      done_o              <= 1'b0;
      total_chunk_start_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          flt_last          <= filter_last_i;
          ifm_last          <= ifm_last_i;
          chunk             <= '0;
          busy_o            <= 1'b1;
          filter_wr_valid_o <= 1'b1;
          state             <= LD_FLT;
        end
        LD_FLT: if (flt_done) begin
          filter_wr_valid_o <= 1'b0;
          filter_wr_sel_o   <= ~filter_wr_sel_o;
          filter_rd_sel_o   <= filter_wr_sel_o;
          ifm_wr_valid_o    <= 1'b1;
          state             <= LD_IFM;
        end
        LD_IFM: if (ifm_done) begin
          ifm_wr_valid_o      <= 1'b0;
          ifm_wr_sel_o        <= ~ifm_wr_sel_o;
          ifm_rd_sel_o        <= ifm_wr_sel_o;
          run_valid_o         <= 1'b1;
          total_chunk_start_o <= 1'b1;
          acc_buf_sel_o       <= OB_W'(32'(chunk) % OUT_BUF_NUM);
          state               <= RUN_START;
        end
        // An end pulse coincident with the start cycle is honoured here too.
        RUN_START, RUN_WAIT: begin
          state <= RUN_WAIT;
          if (total_chunk_end_i) begin
            run_valid_o <= 1'b0;
            out_vld_o   <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: if (drn_en && drn_done) begin
          out_vld_o <= 1'b0;
          if (chunk < ifm_last) begin
            chunk          <= chunk + 1'b1;
            ifm_wr_valid_o <= 1'b1;
            state          <= LD_IFM;
          end else begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_seq_ctrl.sv
// Self-checking bench for cluster_seq_ctrl: records each job's event stream
// and compares it with the sequence the job parameters imply.
module tb_cluster_seq_ctrl;
  import cluster_seq_pkg::*;

  localparam int WC = DEF_WR_CYC_NUM;
  localparam int OB = DEF_OUT_BUF_NUM;
  localparam int CU = DEF_CU_NUM;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  logic [DEF_FL_W-1:0] filter_last_i = '0;
  logic [DEF_IL_W-1:0] ifm_last_i = '0;
  logic total_chunk_end_i = 1'b0;
  logic out_rdy_i = 1'b0;
  logic busy_o, done_o, filter_wr_valid_o, filter_wr_sel_o, filter_rd_sel_o;
  logic ifm_wr_valid_o, ifm_wr_sel_o, ifm_rd_sel_o, run_valid_o, total_chunk_start_o, out_vld_o;
  logic [DEF_WC_W-1:0] filter_wr_count_o, ifm_wr_count_o;
  logic [DEF_OB_W-1:0] filter_wr_order_sel_o, acc_buf_sel_o, out_buf_sel_o;
  logic [DEF_IL_W-1:0] ifm_wr_chunk_count_o;
  logic [DEF_CU_W-1:0] com_unit_out_buf_sel_o;
  logic [26:0] all_outs;

  cluster_seq_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .filter_last_i(filter_last_i), .ifm_last_i(ifm_last_i),
    .busy_o(busy_o), .done_o(done_o),
    .filter_wr_valid_o(filter_wr_valid_o), .filter_wr_count_o(filter_wr_count_o),
    .filter_wr_order_sel_o(filter_wr_order_sel_o),
    .filter_wr_sel_o(filter_wr_sel_o), .filter_rd_sel_o(filter_rd_sel_o),
    .ifm_wr_valid_o(ifm_wr_valid_o), .ifm_wr_count_o(ifm_wr_count_o),
    .ifm_wr_chunk_count_o(ifm_wr_chunk_count_o),
    .ifm_wr_sel_o(ifm_wr_sel_o), .ifm_rd_sel_o(ifm_rd_sel_o),
    .run_valid_o(run_valid_o), .total_chunk_start_o(total_chunk_start_o),
    .total_chunk_end_i(total_chunk_end_i), .acc_buf_sel_o(acc_buf_sel_o),
    .out_buf_sel_o(out_buf_sel_o), .com_unit_out_buf_sel_o(com_unit_out_buf_sel_o),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  assign all_outs = {busy_o, done_o, filter_wr_valid_o, filter_wr_count_o, filter_wr_order_sel_o,
                     filter_wr_sel_o, filter_rd_sel_o, ifm_wr_valid_o, ifm_wr_count_o,
                     ifm_wr_chunk_count_o, ifm_wr_sel_o, ifm_rd_sel_o, run_valid_o,
                     total_chunk_start_o, acc_buf_sel_o, out_buf_sel_o,
                     com_unit_out_buf_sel_o, out_vld_o};

  typedef struct {int cyc; int a; int b; int c;} ev_t;

  int checks = 0;
  int errors = 0;
  bit m_fsel = 1'b0;   // side the next filter load writes
  bit m_isel = 1'b0;   // side the next IFM load writes

  ev_t flt_q[$], ifm_q[$], run_q[$], drn_q[$];
  int  end_q[$], vld_first_q[$];
  int  done_cyc, done_cnt, busy_cnt, vld_cnt, runv_cnt;
  bit  timeout;

  // Drives one job (cycle 0 = start sampled) and records everything it sees.
  task automatic run_job(input int fl, input int il, input int end_dly,
                         input int rdy_pct, input bit noise);
    int cyc, pend_end;
    bit prev_vld;
    flt_q.delete(); ifm_q.delete(); run_q.delete(); drn_q.delete();
    end_q.delete(); vld_first_q.delete();
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; vld_cnt = 0; runv_cnt = 0;
    timeout = 1'b1; pend_end = -1; prev_vld = 1'b0;
    @(negedge clk_i);
    filter_last_i = DEF_FL_W'(fl); ifm_last_i = DEF_IL_W'(il); start_i = 1'b1;
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      cyc++;
      start_i = noise && busy_o && (cyc % 7 == 3);
      total_chunk_end_i = 1'b0;
      if (filter_wr_valid_o)
        flt_q.push_back('{cyc, int'(filter_wr_count_o), int'(filter_wr_order_sel_o), 0});
      if (ifm_wr_valid_o) begin
        ifm_q.push_back('{cyc, int'(ifm_wr_count_o), int'(ifm_wr_chunk_count_o), 0});
        if (noise) total_chunk_end_i = 1'b1;
      end
      if (total_chunk_start_o) begin
        run_q.push_back('{cyc, int'(ifm_wr_sel_o), int'(ifm_rd_sel_o), int'(acc_buf_sel_o)});
        pend_end = cyc + end_dly;
      end
      if (run_valid_o) runv_cnt++;
      if (pend_end == cyc) begin
        total_chunk_end_i = 1'b1;
        end_q.push_back(cyc);
        pend_end = -1;
      end
      if (out_vld_o) begin
        vld_cnt++;
        if (!prev_vld) vld_first_q.push_back(cyc);
      end
      prev_vld = out_vld_o;
      out_rdy_i = (int'($urandom_range(99)) < rdy_pct);
      if (out_vld_o && out_rdy_i)
        drn_q.push_back('{cyc, int'(out_buf_sel_o), int'(com_unit_out_buf_sel_o), int'(acc_buf_sel_o)});
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0 && cyc == done_cyc + 1) begin timeout = 1'b0; break; end
    end
    start_i = 1'b0; total_chunk_end_i = 1'b0; out_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %h want 0", all_outs);
    end
  endtask

  // Full job with stream checks; exp_done < 0 skips the absolute done-cycle check.
  task automatic test_job(input string name, input int fl, input int il, input int end_dly,
                          input int rdy_pct, input bit noise, input int exp_done);
    int nf, nd, exp_cyc, sum;
    bit old_fsel, new_isel;
    nf = (fl + 1) * WC;
    nd = (fl + 1) * CU;
    old_fsel = m_fsel;
    run_job(fl, il, end_dly, rdy_pct, noise);

    checks++;
    if (timeout) begin errors++; $display("FAIL %s timeout: no done_o within budget", name); end

    checks++;
    if (flt_q.size() != nf) begin
      errors++; $display("FAIL %s flt_beats: got %0d want %0d", name, flt_q.size(), nf);
    end else foreach (flt_q[i]) begin
      checks++;
      if (flt_q[i].cyc != 1 + i || flt_q[i].a != i % WC || flt_q[i].b != i / WC) begin
        errors++;
        $display("FAIL %s flt[%0d]: got cyc=%0d cnt=%0d ord=%0d want cyc=%0d cnt=%0d ord=%0d",
                 name, i, flt_q[i].cyc, flt_q[i].a, flt_q[i].b, 1 + i, i % WC, i / WC);
      end
    end

    checks++;
    if (ifm_q.size() != (il + 1) * WC || drn_q.size() != (il + 1) * nd) begin
      errors++;
      $display("FAIL %s beat_totals: got ifm=%0d drain=%0d want ifm=%0d drain=%0d",
               name, ifm_q.size(), drn_q.size(), (il + 1) * WC, (il + 1) * nd);
    end else begin
      foreach (ifm_q[i]) begin
        exp_cyc = (i / WC == 0) ? nf + 1 + i % WC : drn_q[(i / WC) * nd - 1].cyc + 1 + i % WC;
        checks++;
        if (ifm_q[i].cyc != exp_cyc || ifm_q[i].a != i % WC || ifm_q[i].b != i / WC) begin
          errors++;
          $display("FAIL %s ifm[%0d]: got cyc=%0d cnt=%0d chunk=%0d want cyc=%0d cnt=%0d chunk=%0d",
                   name, i, ifm_q[i].cyc, ifm_q[i].a, ifm_q[i].b, exp_cyc, i % WC, i / WC);
        end
      end
      foreach (drn_q[j]) begin
        checks++;
        if (drn_q[j].a != (j % nd) / CU || drn_q[j].b != (j % nd) % CU || drn_q[j].c != (j / nd) % OB) begin
          errors++;
          $display("FAIL %s drain[%0d]: got buf=%0d cu=%0d acc=%0d want buf=%0d cu=%0d acc=%0d",
                   name, j, drn_q[j].a, drn_q[j].b, drn_q[j].c, (j % nd) / CU, (j % nd) % CU, (j / nd) % OB);
        end
      end
    end

    checks++;
    if (run_q.size() != il + 1 || end_q.size() != il + 1 || vld_first_q.size() != il + 1) begin
      errors++;
      $display("FAIL %s run_count: got starts=%0d ends=%0d drains=%0d want %0d",
               name, run_q.size(), end_q.size(), vld_first_q.size(), il + 1);
    end else if (ifm_q.size() == (il + 1) * WC && drn_q.size() == (il + 1) * nd) begin
      sum = 0;
      foreach (run_q[c]) begin
        new_isel = ~m_isel;
        checks++;
        if (run_q[c].cyc != ifm_q[c * WC + WC - 1].cyc + 1 || run_q[c].a != int'(new_isel) ||
            run_q[c].b != int'(m_isel) || run_q[c].c != c % OB) begin
          errors++;
          $display("FAIL %s run[%0d]: got cyc=%0d wr=%0d rd=%0d acc=%0d want cyc=%0d wr=%0d rd=%0d acc=%0d",
                   name, c, run_q[c].cyc, run_q[c].a, run_q[c].b, run_q[c].c,
                   ifm_q[c * WC + WC - 1].cyc + 1, new_isel, m_isel, c % OB);
        end
        m_isel = new_isel;
        checks++;
        if (vld_first_q[c] != end_q[c] + 1) begin
          errors++;
          $display("FAIL %s drain_start[%0d]: got %0d want %0d", name, c, vld_first_q[c], end_q[c] + 1);
        end
        sum += end_q[c] - run_q[c].cyc + 1;
      end
      checks++;
      if (runv_cnt != sum) begin
        errors++; $display("FAIL %s run_valid_cycles: got %0d want %0d", name, runv_cnt, sum);
      end
      sum = 0;
      foreach (vld_first_q[c]) sum += drn_q[(c + 1) * nd - 1].cyc - vld_first_q[c] + 1;
      checks++;
      if (vld_cnt != sum) begin
        errors++; $display("FAIL %s out_vld_cycles: got %0d want %0d", name, vld_cnt, sum);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != drn_q[drn_q.size() - 1].cyc + 1 || busy_cnt != done_cyc - 1) begin
        errors++;
        $display("FAIL %s done: got pulses=%0d cyc=%0d busy=%0d want pulses=1 cyc=%0d busy=%0d",
                 name, done_cnt, done_cyc, busy_cnt, drn_q[drn_q.size() - 1].cyc + 1,
                 drn_q[drn_q.size() - 1].cyc);
      end
    end

    if (exp_done >= 0) begin
      checks++;
      if (done_cyc != exp_done) begin
        errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
      end
    end

    m_fsel = ~old_fsel;
    checks++;
    if (filter_wr_sel_o !== m_fsel || filter_rd_sel_o !== old_fsel) begin
      errors++;
      $display("FAIL %s filter_sel: got wr=%0b rd=%0b want wr=%0b rd=%0b",
               name, filter_wr_sel_o, filter_rd_sel_o, m_fsel, old_fsel);
    end
  endtask

  task automatic test_reset_mid_job();
    bit found = 1'b0;
    @(negedge clk_i);
    filter_last_i = 2'd2; ifm_last_i = 3'd1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (run_valid_o && !total_chunk_start_o) begin found = 1'b1; break; end
      @(negedge clk_i);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reset: RUN_WAIT never reached"); end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h want 0", all_outs);
    end
    rst_i = 1'b1;
    m_fsel = 1'b0; m_isel = 1'b0;
    @(negedge clk_i);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL mid_reset_no_done: got %h want 0", all_outs);
    end
    test_job("after_reset", 1, 1, 2, 100, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_job("multi_chunk", 1, 2, 3, 100, 1'b0, -1);
    test_job("basic", 1, 0, 5, 100, 1'b0, 35);
    test_job("stall", 3, 1, 4, 45, 1'b0, -1);
    test_job("ignored_inputs", 2, 1, 3, 100, 1'b1, -1);
    test_job("coincident_end", 0, 1, 0, 100, 1'b0, -1);
    test_reset_mid_job();
    for (int r = 0; r < 5; r++)
      test_job("random", int'($urandom_range(3)), int'($urandom_range(3)),
               int'($urandom_range(6)), int'($urandom_range(100, 30)), 1'($urandom_range(1)), -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
